// File: rtl/result_sel_pipe.sv
// result_sel_pipe: one-hot operand selector feeding a single-stage registered
// output buffer with valid/ready handshaking on both sides.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset
//   in_bus     - NSEL packed operand slices, slice i = in_bus[i*WIDTH +: WIDTH]
//   sel        - one-hot operation select
//   in_valid   - in_bus/sel valid this cycle
//   in_ready   - block accepts a transfer this cycle
//   res        - registered selected result
//   res_valid  - res holds an unconsumed result
//   out_ready  - downstream consumes res this cycle
//   res_zero   - registered flag, res == 0
//   res_neg    - registered flag, res MSB
//   sel_err    - registered flag, captured sel was not legal one-hot
//   err_sticky - set by any illegal-select capture, cleared by clr_err
//   err_cnt    - saturating count of illegal-select captures
//   clr_err    - synchronous clear of err_sticky and err_cnt
module result_sel_pipe #(
  parameter int WIDTH     = 16,
  parameter int NSEL      = 12,
  parameter int CLEAR_IDX = NSEL - 1,
  parameter int ERRW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSEL*WIDTH-1:0] in_bus,
  input  logic [NSEL-1:0]       sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      res,
  output logic                  res_valid,
  input  logic                  out_ready,
  output logic                  res_zero,
  output logic                  res_neg,
  output logic                  sel_err,
  output logic                  err_sticky,
  output logic [ERRW-1:0]       err_cnt,
  input  logic                  clr_err
);

  localparam int unsigned CLR = CLEAR_IDX;

  logic             sel_legal;
  logic [WIDTH-1:0] pick;
  logic [WIDTH-1:0] res_next;
  logic             accept;
  logic             bad_accept;

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign sel_legal = (sel != '0) && ((sel & (sel - NSEL'(1))) == '0);

  // AND-OR mux; gating with sel_legal keeps multi-hot selects from merging slices.
  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < NSEL; i++) begin
      if (sel[i] && (i != CLR)) begin
        pick = pick | in_bus[i*WIDTH +: WIDTH];
      end
    end
    res_next = sel_legal ? pick : '0;
  end

  assign in_ready   = !res_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign bad_accept = accept && !sel_legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      res_valid <= 1'b0;
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
      sel_err   <= 1'b0;
    end else if (accept) begin
      res       <= res_next;
      res_valid <= 1'b1;
      res_zero  <= (res_next == '0);
      res_neg   <= res_next[WIDTH-1];
      sel_err   <= !sel_legal;
    end else if (out_ready) begin
      res_valid <= 1'b0;
    end
  end

  // Clear wins over history but not over an illegal capture in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (clr_err) begin
      err_sticky <= bad_accept;
      err_cnt    <= bad_accept ? ERRW'(1) : '0;
    end else if (bad_accept) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) begin
        err_cnt <= err_cnt + ERRW'(1);
      end
    end
  end

endmodule

// File: tb/tb_result_sel_pipe.sv
// tb_result_sel_pipe: directed test of result_sel_pipe with a behavioural
// reference model checked every cycle, plus literal expectations.
// Two instances share stimulus: default parameters, and ERRW = 2 for saturation.
module tb_result_sel_pipe;

  localparam int W = 16;
  localparam int N = 12;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N*W-1:0] in_bus = '0;
  logic [N-1:0]   sel = '0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic           clr_err = 1'b0;

  logic           in_ready, res_valid, res_zero, res_neg, sel_err, err_sticky;
  logic [W-1:0]   res;
  logic [7:0]     err_cnt;

  logic           in_ready2, res_valid2, res_zero2, res_neg2, sel_err2, err_sticky2;
  logic [W-1:0]   res2;
  logic [1:0]     err_cnt2;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  result_sel_pipe dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .res(res), .res_valid(res_valid), .out_ready(out_ready),
    .res_zero(res_zero), .res_neg(res_neg), .sel_err(sel_err),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .clr_err(clr_err)
  );

  result_sel_pipe #(.ERRW(2)) dut2 (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready2), .res(res2), .res_valid(res_valid2), .out_ready(out_ready),
    .res_zero(res_zero2), .res_neg(res_neg2), .sel_err(sel_err2),
    .err_sticky(err_sticky2), .err_cnt(err_cnt2), .clr_err(clr_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_res = '0;
  logic         m_valid = 1'b0, m_zero = 1'b0, m_neg = 1'b0, m_err = 1'b0, m_sticky = 1'b0;
  int           m_cnt8 = 0, m_cnt2 = 0;

  logic [W-1:0] n_res;
  logic         n_valid, n_zero, n_neg, n_err, n_sticky, acc, ill;
  int           n_cnt8, n_cnt2;

  // Selected value from the rules: exactly one bit -> that slice (or zero for
  // the clear bit); anything else -> zero and an error.
  function automatic logic [W:0] model_pick(input logic [N*W-1:0] b, input logic [N-1:0] s);
    int idx;
    if ($countones(s) != 1) return {1'b1, {W{1'b0}}};
    idx = 0;
    for (int k = 0; k < N; k++) if (s[k]) idx = k;
    if (idx == N - 1) return '0;
    return {1'b0, b[idx*W +: W]};
  endfunction

  always_comb begin
    logic [W:0] p;
    p        = model_pick(in_bus, sel);
    acc      = in_valid && (!m_valid || out_ready);
    ill      = acc && p[W];
    n_res    = m_res;
    n_valid  = m_valid;
    n_zero   = m_zero;
    n_neg    = m_neg;
    n_err    = m_err;
    if (acc) begin
      n_res   = p[W-1:0];
      n_valid = 1'b1;
      n_zero  = (p[W-1:0] == 0);
      n_neg   = p[W-1];
      n_err   = p[W];
    end else if (out_ready) begin
      n_valid = 1'b0;
    end
    if (clr_err) begin
      n_sticky = ill;
      n_cnt8   = ill ? 1 : 0;
      n_cnt2   = ill ? 1 : 0;
    end else begin
      n_sticky = m_sticky | ill;
      n_cnt8   = (ill && m_cnt8 < 255) ? m_cnt8 + 1 : m_cnt8;
      n_cnt2   = (ill && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res <= '0; m_valid <= 1'b0; m_zero <= 1'b0; m_neg <= 1'b0;
      m_err <= 1'b0; m_sticky <= 1'b0; m_cnt8 <= 0; m_cnt2 <= 0;
    end else begin
      m_res <= n_res; m_valid <= n_valid; m_zero <= n_zero; m_neg <= n_neg;
      m_err <= n_err; m_sticky <= n_sticky; m_cnt8 <= n_cnt8; m_cnt2 <= n_cnt2;
    end
  end

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) begin
    chk("m_res",       32'(res),         32'(m_res));
    chk("m_res_valid", 32'(res_valid),   32'(m_valid));
    chk("m_res_zero",  32'(res_zero),    32'(m_zero));
    chk("m_res_neg",   32'(res_neg),     32'(m_neg));
    chk("m_sel_err",   32'(sel_err),     32'(m_err));
    chk("m_sticky",    32'(err_sticky),  32'(m_sticky));
    chk("m_err_cnt",   32'(err_cnt),     32'(m_cnt8));
    chk("m_in_ready",  32'(in_ready),    32'(!m_valid || out_ready));
    chk("m_res_b",     32'(res2),        32'(m_res));
    chk("m_sticky_b",  32'(err_sticky2), 32'(m_sticky));
    chk("m_err_cnt_b", 32'(err_cnt2),    32'(m_cnt2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [W-1:0] stream_v [8];

    #1 rst = 1'b1;
    #1;
    chk("rst_res",       32'(res),        32'h0);
    chk("rst_res_valid", 32'(res_valid),  32'h0);
    chk("rst_err_cnt",   32'(err_cnt),    32'h0);
    chk("rst_in_ready",  32'(in_ready),   32'h1);
    @(negedge clk);
    #2 rst = 1'b0;

    // Single transfer from slice 7.
    in_bus = '0;
    in_bus[7*W +: W] = 16'h1234;
    sel = 12'h080; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("single_res",   32'(res),       32'h1234);
    chk("single_valid", 32'(res_valid), 32'h1);
    chk("single_zero",  32'(res_zero),  32'h0);
    chk("single_neg",   32'(res_neg),   32'h0);
    chk("single_err",   32'(sel_err),   32'h0);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(res_valid), 32'h0);

    // Backpressure holds result while inputs churn.
    in_bus[0 +: W] = 16'h8001;
    sel = 12'h001; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    for (int c = 0; c < 3; c++) begin
      in_bus = {6{32'($urandom)}};
      sel = 12'($urandom);
      tick();
      chk("bp_in_ready", 32'(in_ready),  32'h0);
      chk("bp_res",      32'(res),       32'h8001);
      chk("bp_neg",      32'(res_neg),   32'h1);
      chk("bp_valid",    32'(res_valid), 32'h1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(res_valid), 32'h0);
    chk("bp_release_res",   32'(res),       32'h8001);

    // Input changes without accept leave outputs untouched.
    for (int c = 0; c < 3; c++) begin
      in_bus = {6{32'($urandom)}};
      sel = 12'($urandom);
      tick();
    end

    // Illegal selects: two bits, then none.
    in_bus = {N{16'hA5A5}};
    in_valid = 1'b1;
    sel = 12'h003;
    tick();
    chk("ill2_res",  32'(res),      32'h0);
    chk("ill2_err",  32'(sel_err),  32'h1);
    chk("ill2_zero", 32'(res_zero), 32'h1);
    sel = 12'h000;
    tick();
    chk("ill0_res",    32'(res),        32'h0);
    chk("ill0_err",    32'(sel_err),    32'h1);
    chk("ill0_zero",   32'(res_zero),   32'h1);
    chk("ill_cnt",     32'(err_cnt),    32'h2);
    chk("ill_sticky",  32'(err_sticky), 32'h1);

    // Clear select ignores its slice.
    in_bus = {N{16'hFFFF}};
    sel = 12'h800;
    tick();
    chk("clr_sel_res", 32'(res),     32'h0);
    chk("clr_sel_err", 32'(sel_err), 32'h0);

    // Saturation on the narrow counter.
    sel = 12'h0C0;
    for (int c = 0; c < 5; c++) tick();
    chk("sat_cnt2", 32'(err_cnt2), 32'h3);
    chk("sat_cnt8", 32'(err_cnt),  32'h7);
    in_valid = 1'b0; clr_err = 1'b1;
    tick();
    chk("clr_cnt",    32'(err_cnt),    32'h0);
    chk("clr_cnt2",   32'(err_cnt2),   32'h0);
    chk("clr_sticky", 32'(err_sticky), 32'h0);
    in_valid = 1'b1; sel = 12'h000;
    tick();
    chk("clr_ill_cnt",    32'(err_cnt),    32'h1);
    chk("clr_ill_sticky", 32'(err_sticky), 32'h1);
    clr_err = 1'b0;

    // Streaming: 8 back-to-back accepts.
    for (int k = 0; k < 8; k++) stream_v[k] = 16'(16'h1111 * (k + 1) + 16'h0100);
    for (int k = 0; k < 8; k++) begin
      in_bus = '0;
      in_bus[k*W +: W] = stream_v[k];
      sel = 12'(1 << k);
      tick();
      chk("stream_res",   32'(res),       32'(stream_v[k]));
      chk("stream_valid", 32'(res_valid), 32'h1);
    end

    // Asynchronous reset mid-stream.
    in_bus[3*W +: W] = 16'hBEEF;
    sel = 12'h008;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(res_valid), 32'h0);
    chk("arst_res",   32'(res),       32'h0);
    chk("arst_cnt",   32'(err_cnt),   32'h0);
    tick();
    chk("arst_hold_valid", 32'(res_valid), 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    chk("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    chk("post_rst_res",   32'(res),       32'hBEEF);
    chk("post_rst_valid", 32'(res_valid), 32'h1);
    in_valid = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
